alu_seq: RTL and testbench

- Multi-word operation sequencer that sits directly upstream of the 32-bit ALU.
- Accepts one 32*WORDS-bit request through a valid/ready handshake.
- Drives the ALU's A/B/OP/C_IN ports one 32-bit word per cycle, least-significant word first, chaining the carry between words.
- Captures the ALU's OUT/Z/C results and presents the assembled wide result and flags to the writeback stage through a valid/ready handshake.

---
 rtl/common.sv | 11 +
 rtl/alu_seq.sv | 158 +++++++++++++++
 tb/tb_alu_seq.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/common.sv
// Shared ALU operation encodings used by the ALU and everything that drives it.
package common;
    localparam logic [2:0] ALU_NOP0 = 3'd0;
    localparam logic [2:0] ALU_ADD  = 3'd1;
    localparam logic [2:0] ALU_SUB  = 3'd2;
    localparam logic [2:0] ALU_AND  = 3'd3;
    localparam logic [2:0] ALU_OR   = 3'd4;
    localparam logic [2:0] ALU_XOR  = 3'd5;
    localparam logic [2:0] ALU_NOT  = 3'd6;
    localparam logic [2:0] ALU_NOP1 = 3'd7;
endpackage

// File: rtl/alu_seq.sv
// Wide-operation sequencer: splits a WORDS x 32-bit request into carry-chained
// single-word ALU operations and reassembles the result for writeback.
module alu_seq #(
    parameter int WORDS = 2
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                REQ_VALID,
    output logic                REQ_READY,
    input  logic [32*WORDS-1:0] REQ_A,
    input  logic [32*WORDS-1:0] REQ_B,
    input  logic [2:0]          REQ_OP,
    input  logic                REQ_C_IN,
    input  logic                REQ_WIDE,
    output logic [31:0]         ALU_A,
    output logic [31:0]         ALU_B,
    output logic [2:0]          ALU_OP,
    output logic                ALU_C_IN,
    input  logic [31:0]         ALU_OUT,
    input  logic                ALU_Z,
    input  logic                ALU_C,
    output logic                RES_VALID,
    input  logic                RES_READY,
    output logic [32*WORDS-1:0] RES_OUT,
    output logic                RES_Z,
    output logic                RES_C,
    output logic                RES_N
);
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state_reg, state_next;

    logic [32*WORDS-1:0] a_reg, b_reg;
    logic [2:0]          op_reg;
    logic                c_in_reg, wide_reg;
    logic [IW-1:0]       idx_reg;
    logic                primed_reg;   // ALU ports currently hold word idx_reg
    logic                z_acc_reg;
    logic [31:0]         work_reg [WORDS];
    logic [31:0]         res_reg  [WORDS];

    logic [31:0]   a_word [WORDS];
    logic [31:0]   b_word [WORDS];
    logic [IW-1:0] last_idx, idx_fetch;
    logic          last_word, arith, fetch_cin;

    generate
        for (genvar gi = 0; gi < WORDS; gi++) begin : g_words
            assign a_word[gi] = a_reg[gi*32 +: 32];
            assign b_word[gi] = b_reg[gi*32 +: 32];
            assign RES_OUT[gi*32 +: 32] = res_reg[gi];
        end
    endgenerate

    assign last_idx  = wide_reg ? IW'(WORDS - 1) : '0;
    assign last_word = primed_reg && (idx_reg == last_idx);
    assign arith     = (op_reg == common::ALU_ADD) || (op_reg == common::ALU_SUB);
    assign idx_fetch = primed_reg ? idx_reg + 1'b1 : '0;
    assign REQ_READY = (state_reg == IDLE);
    assign RES_VALID = (state_reg == DONE);

    // Word 0 takes the request carry (or 1 for subtraction); later words chain the live ALU carry.
    always_comb begin
        fetch_cin = 1'b0;
        if (primed_reg)
            fetch_cin = arith & ALU_C;
        else if (op_reg == common::ALU_SUB)
            fetch_cin = 1'b1;
        else if (op_reg == common::ALU_ADD)
            fetch_cin = c_in_reg;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (REQ_VALID) state_next = RUN;
            RUN:     if (last_word) state_next = DONE;
            DONE:    if (RES_READY) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            a_reg      <= '0;
            b_reg      <= '0;
            op_reg     <= common::ALU_NOP0;
            c_in_reg   <= 1'b0;
            wide_reg   <= 1'b0;
            idx_reg    <= '0;
            primed_reg <= 1'b0;
            z_acc_reg  <= 1'b0;
            for (int i = 0; i < WORDS; i++) begin
                work_reg[i] <= '0;
                res_reg[i]  <= '0;
            end
            RES_Z    <= 1'b0;
            RES_C    <= 1'b0;
            RES_N    <= 1'b0;
            ALU_A    <= '0;
            ALU_B    <= '0;
            ALU_OP   <= common::ALU_NOP0;
            ALU_C_IN <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (REQ_VALID) begin
                        a_reg      <= REQ_A;
                        b_reg      <= REQ_B;
                        op_reg     <= REQ_OP;
                        c_in_reg   <= REQ_C_IN;
                        wide_reg   <= REQ_WIDE;
                        idx_reg    <= '0;
                        primed_reg <= 1'b0;
                        z_acc_reg  <= 1'b1;
                        for (int i = 0; i < WORDS; i++)
                            work_reg[i] <= '0;
                    end
                end
                RUN: begin
                    if (last_word) begin
                        // Publish the whole result at once so a partial result is never visible.
                        for (int i = 0; i < WORDS; i++)
                            res_reg[i] <= (IW'(i) == idx_reg) ? ALU_OUT : work_reg[i];
                        RES_Z      <= z_acc_reg & ALU_Z;
                        RES_C      <= arith & ALU_C;
                        RES_N      <= ALU_OUT[31];
                        primed_reg <= 1'b0;
                        ALU_A      <= '0;
                        ALU_B      <= '0;
                        ALU_OP     <= common::ALU_NOP0;
                        ALU_C_IN   <= 1'b0;
                    end else begin
                        if (primed_reg) begin
                            work_reg[idx_reg] <= ALU_OUT;
                            z_acc_reg         <= z_acc_reg & ALU_Z;
                        end
                        ALU_A      <= a_word[idx_fetch];
                        ALU_B      <= (op_reg == common::ALU_SUB) ? ~b_word[idx_fetch] : b_word[idx_fetch];
                        ALU_OP     <= arith ? common::ALU_ADD : op_reg;
                        ALU_C_IN   <= fetch_cin;
                        idx_reg    <= idx_fetch;
                        primed_reg <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: a behavioural 32-bit ALU feeds the DUT, and results
// are compared against whole-width arithmetic on the original request.
module tb_alu_seq;
    localparam int WORDS = 2;
    localparam int W = 32 * WORDS;

    typedef struct {
        logic [63:0] out;
        logic        z, c, n;
        int          lat;
        int          acc;
        logic [2:0]  op;
    } exp_t;

    logic         clk, rst;
    logic         req_valid, req_ready, req_c_in, req_wide;
    logic [W-1:0] req_a, req_b;
    logic [2:0]   req_op;
    logic [31:0]  alu_a, alu_b, alu_out;
    logic [2:0]   alu_op;
    logic         alu_c_in, alu_z, alu_c;
    logic         res_valid, res_ready, res_z, res_c, res_n;
    logic [W-1:0] res_out;

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    exp_t sb_q[$];
    logic alu_log[$];
    logic log_en = 1'b0;
    logic [63:0] last_out;
    logic last_z, last_c, last_n;

    alu_seq #(.WORDS(WORDS)) dut (
        .CLK(clk), .RST(rst),
        .REQ_VALID(req_valid), .REQ_READY(req_ready),
        .REQ_A(req_a), .REQ_B(req_b), .REQ_OP(req_op), .REQ_C_IN(req_c_in), .REQ_WIDE(req_wide),
        .ALU_A(alu_a), .ALU_B(alu_b), .ALU_OP(alu_op), .ALU_C_IN(alu_c_in),
        .ALU_OUT(alu_out), .ALU_Z(alu_z), .ALU_C(alu_c),
        .RES_VALID(res_valid), .RES_READY(res_ready),
        .RES_OUT(res_out), .RES_Z(res_z), .RES_C(res_c), .RES_N(res_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    // Single-word ALU the sequencer drives.
    always_comb begin
        logic [32:0] sum;
        sum = {1'b0, alu_a} + {1'b0, alu_b} + {32'd0, alu_c_in};
        alu_out = '0;
        alu_c   = 1'b0;
        case (alu_op)
            common::ALU_ADD: begin alu_out = sum[31:0]; alu_c = sum[32]; end
            common::ALU_AND: alu_out = alu_a & alu_b;
            common::ALU_OR:  alu_out = alu_a | alu_b;
            common::ALU_XOR: alu_out = alu_a ^ alu_b;
            common::ALU_NOT: alu_out = ~alu_a;
            default:         alu_out = '0;
        endcase
        alu_z = (alu_out == '0);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // Reference: the whole operand treated as one number.
    function automatic exp_t model(logic [63:0] a, logic [63:0] b, logic [2:0] op, logic cin, logic wide);
        exp_t e;
        logic [63:0] mask, r;
        logic [64:0] full;
        logic c;
        mask = wide ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        a = a & mask;
        b = b & mask;
        c = 1'b0;
        full = {1'b0, a} + {1'b0, b} + {64'd0, cin};
        case (op)
            common::ALU_ADD: begin r = full[63:0] & mask; c = wide ? full[64] : full[32]; end
            common::ALU_SUB: begin r = (a - b) & mask; c = (a >= b); end
            common::ALU_AND: r = a & b;
            common::ALU_OR:  r = a | b;
            common::ALU_XOR: r = a ^ b;
            common::ALU_NOT: r = ~a & mask;
            default:         r = '0;
        endcase
        e.out = r;
        e.z   = (r == '0);
        e.c   = c;
        e.n   = wide ? r[63] : r[31];
        e.lat = wide ? WORDS + 1 : 2;
        e.acc = 0;
        e.op  = op;
        return e;
    endfunction

    // Called at a falling edge; returns at the falling edge after the accepting edge.
    task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic [2:0] op,
                         input logic cin, input logic wide, output int acc);
        exp_t e;
        int n;
        n = 0;
        acc = -1;
        req_a = a; req_b = b; req_op = op; req_c_in = cin; req_wide = wide;
        req_valid = 1'b1;
        while (acc < 0 && n < 60) begin
            if (req_ready) begin
                acc = cyc + 1;
                e = model(a, b, op, cin, wide);
                e.acc = acc;
                sb_q.push_back(e);
            end
            @(negedge clk);
            n++;
        end
        req_valid = 1'b0;
        if (acc < 0) check("issue_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_drain();
        int n;
        bit ok;
        n = 0;
        ok = 1'b0;
        while (!ok && n < 200) begin
            @(negedge clk); #2;
            if (sb_q.size() == 0 && !res_valid) ok = 1'b1;
            n++;
        end
        if (!ok) check("drain_timeout", 64'd0, 64'd1);
    endtask

    // Monitor: pops the scoreboard whenever a result is retired.
    always begin : monitor
        logic        prev_valid;
        logic [63:0] prev_out;
        int          rise_cyc;
        exp_t        e;
        prev_valid = 1'b0;
        prev_out   = '0;
        rise_cyc   = 0;
        forever begin
            @(negedge clk); #1;
            if (rst) begin
                prev_valid = 1'b0;
            end else begin
                if (res_valid && !prev_valid) rise_cyc = cyc;
                if (res_valid && prev_valid) check("res_stable", res_out, prev_out);
                if (res_valid) check("req_ready_in_done", {63'd0, req_ready}, 64'd0);
                if (res_valid && res_ready) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_result", 64'd1, 64'd0);
                    end else begin
                        e = sb_q.pop_front();
                        check("res_out", res_out, e.out);
                        check("res_z", {63'd0, res_z}, {63'd0, e.z});
                        check("res_c", {63'd0, res_c}, {63'd0, e.c});
                        check("res_n", {63'd0, res_n}, {63'd0, e.n});
                        check("latency", 64'(rise_cyc - e.acc), 64'(e.lat));
                        $display("[TB] result op=%0d out=0x%016h z=%0b c=%0b n=%0b", e.op, res_out, res_z, res_c, res_n);
                    end
                    last_out = res_out;
                    last_z = res_z;
                    last_c = res_c;
                    last_n = res_n;
                end
                prev_valid = res_valid;
                prev_out   = res_out;
            end
        end
    end

    always begin
        @(negedge clk); #1;
        if (log_en && alu_op == common::ALU_ADD) alu_log.push_back(alu_c_in);
    end

    function automatic logic [31:0] pick_word();
        case ($urandom_range(0, 3))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'($urandom_range(0, 3));
            default: return $urandom();
        endcase
    endfunction

    initial begin
        int acc, acc_y, rel_cyc;
        logic [63:0] held;
        bit rand_done;
        rst = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0; req_op = common::ALU_NOP0;
        req_c_in = 1'b0; req_wide = 1'b0; res_ready = 1'b1;
        rel_cyc = 0; held = '0;
        repeat (3) @(negedge clk);
        #2;
        check("rst_res_valid", {63'd0, res_valid}, 64'd0);
        check("rst_res_out", res_out, 64'd0);
        check("rst_flags", {61'd0, res_z, res_c, res_n}, 64'd0);
        check("rst_req_ready", {63'd0, req_ready}, 64'd1);
        check("rst_alu_ab", {alu_a, alu_b}, 64'd0);
        check("rst_alu_op", {60'd0, alu_op, alu_c_in}, {60'd0, common::ALU_NOP0, 1'b0});
        @(negedge clk); rst = 1'b0;
        @(negedge clk);

        issue(64'h00000000_FFFFFFFF, 64'h1, common::ALU_ADD, 1'b0, 1'b1, acc);
        wait_drain();
        check("add_out", last_out, 64'h00000001_00000000);
        check("add_czn", {61'd0, last_c, last_z, last_n}, 64'd0);

        alu_log.delete();
        log_en = 1'b1;
        issue(64'h0, 64'h1, common::ALU_SUB, 1'b0, 1'b1, acc);
        wait_drain();
        log_en = 1'b0;
        check("sub_out", last_out, 64'hFFFFFFFF_FFFFFFFF);
        check("sub_czn", {61'd0, last_c, last_z, last_n}, 64'd1);
        check("sub_alu_words", 64'(alu_log.size()), 64'd2);
        if (alu_log.size() == 2) begin
            check("sub_cin_w0", {63'd0, alu_log[0]}, 64'd1);
            check("sub_cin_w1", {63'd0, alu_log[1]}, 64'd0);
        end

        issue(64'h12345678_9ABCDEF0, 64'h12345678_9ABCDEF0, common::ALU_XOR, 1'b0, 1'b1, acc);
        wait_drain();
        check("xor_out", last_out, 64'd0);
        check("xor_zc", {62'd0, last_z, last_c}, 64'd2);

        issue(64'hFFFFFFFF_FFFFFFFF, 64'h1, common::ALU_ADD, 1'b0, 1'b0, acc);
        wait_drain();
        check("narrow_out", last_out, 64'd0);
        check("narrow_cz", {62'd0, last_c, last_z}, 64'd3);

        // Backpressure with a second request pending.
        @(negedge clk); res_ready = 1'b0;
        issue(64'h0F0F0000_12340000, 64'h00F00000_00005678, common::ALU_OR, 1'b0, 1'b1, acc);
        fork
            issue(64'h00000001_00000002, 64'h00000003_00000004, common::ALU_ADD, 1'b0, 1'b1, acc_y);
            begin
                int n;
                n = 0;
                #3;
                while (!res_valid && n < 30) begin @(negedge clk); #3; n++; end
                check("bp_reached_done", {63'd0, res_valid}, 64'd1);
                held = res_out;
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk); #3;
                    check("bp_req_ready", {63'd0, req_ready}, 64'd0);
                    check("bp_hold", {res_out[62:0], res_valid}, {held[62:0], 1'b1});
                end
                @(negedge clk);
                res_ready = 1'b1;
                rel_cyc = cyc;
            end
        join
        check("bp_accept_edge", 64'(acc_y), 64'(rel_cyc + 2));
        wait_drain();
        check("bp_second_out", last_out, 64'h00000004_00000006);

        // Reset while word 1 of a wide ADD is on the ALU.
        issue(64'h00000007_00000009, 64'h00000001_00000001, common::ALU_ADD, 1'b0, 1'b1, acc);
        @(negedge clk);
        @(negedge clk); #2;
        check("rst_run_word1", {32'd0, alu_a}, 64'd7);
        rst = 1'b1; #1;
        check("rst_run_valid", {63'd0, res_valid}, 64'd0);
        check("rst_run_out", res_out, 64'd0);
        check("rst_run_alu_op", {61'd0, alu_op}, {61'd0, common::ALU_NOP0});
        if (sb_q.size() > 0) void'(sb_q.pop_back());
        @(negedge clk); rst = 1'b0; #2;
        check("rst_run_ready", {63'd0, req_ready}, 64'd1);
        issue(64'd2, 64'd3, common::ALU_ADD, 1'b0, 1'b1, acc);
        wait_drain();
        check("rst_next_add", last_out, 64'd5);

        rand_done = 1'b0;
        fork
            begin
                for (int t = 0; t < 40; t++) begin
                    issue({pick_word(), pick_word()}, {pick_word(), pick_word()},
                          3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 3) != 0), acc);
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(negedge clk);
                    res_ready = ($urandom_range(0, 3) != 0);
                end
                res_ready = 1'b1;
            end
        join
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
